rpc_trx_scheduler: RTL and testbench

//  Sits between the AXI front-end request queues and the DRAM command FSM.

---
 rtl/rpc_sched_pkg.sv | 30 +++
 rtl/rpc_read_credit_counter.sv | 71 +++++++
 rtl/rpc_trx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_rpc_trx_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpc_sched_pkg.sv
// rpc_sched_pkg
// Shared types and sizing helpers for the RPC transaction scheduler.
//   state_e     - scheduler FSM states (IDLE, ISSUE)
//   cmd_t       - latched DRAM command {is_write, addr, len}
//   rbuf_depth  - read-data SRAM depth in words for a given buffer configuration
// cmd_t is sized by ADDR_WIDTH/LEN_WIDTH below; the scheduler parameters
// default to these, so any override must be mirrored here.
package rpc_sched_pkg;

    localparam int unsigned ADDR_WIDTH = 27;
    localparam int unsigned LEN_WIDTH  = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic                  is_write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } cmd_t;

    // Each buffered transaction can carry up to 2^len_width words.
    function automatic int unsigned rbuf_depth(input int unsigned buffer_depth,
                                               input int unsigned len_width);
        return buffer_depth << len_width;
    endfunction

endpackage

// File: rtl/rpc_read_credit_counter.sv
// rpc_read_credit_counter
// Tracks free words in the read-data SRAM. Words are reserved when a read is
// granted and returned one at a time as the SRAM drains toward AXI.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset (credits -> full)
//   req_len_i       beats-1 of the read currently requesting a grant
//   space_ok_o      that read fits in the free space
//   reserve_i       read granted this cycle
//   reserve_len_i   beats-1 of the granted read
//   release_i       one word popped from the SRAM
//   credits_o       free words
module rpc_read_credit_counter
    import rpc_sched_pkg::*;
#(
    parameter int unsigned  BufferDepth  = 4,
    parameter int unsigned  DramLenWidth = LEN_WIDTH,
    localparam int unsigned RBufDepth    = rbuf_depth(BufferDepth, DramLenWidth),
    localparam int unsigned RDepth       = $clog2(RBufDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DramLenWidth-1:0] req_len_i,
    output logic                    space_ok_o,
    input  logic                    reserve_i,
    input  logic [DramLenWidth-1:0] reserve_len_i,
    input  logic                    release_i,
    output logic [RDepth:0]         credits_o
);

    localparam logic [RDepth:0] FULL = (RDepth+1)'(RBufDepth);
    localparam logic [RDepth:0] ONE  = (RDepth+1)'(1);

    logic [RDepth:0] credits_q;
    logic [RDepth:0] credits_d;
    logic [RDepth:0] req_words;
    logic [RDepth:0] reserve_words;

    // Lengths are widened before the +1 so that len=max cannot wrap.
    assign req_words     = {{(RDepth+1-DramLenWidth){1'b0}}, req_len_i} + ONE;
    assign reserve_words = {{(RDepth+1-DramLenWidth){1'b0}}, reserve_len_i} + ONE;
    assign space_ok_o    = (req_words <= credits_q);
    assign credits_o     = credits_q;

    // Reserve and release in the same cycle apply their net effect. A pop
    // while already full has no word to return and is ignored.
    always_comb begin
        credits_d = credits_q;
        if (reserve_i) begin
            credits_d = credits_d - reserve_words;
        end
        if (release_i && (credits_q != FULL)) begin
            credits_d = credits_d + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q <= FULL;
        end else begin
            credits_q <= credits_d;
        end
    end

    // A pop at full credits means the downstream SRAM accounting is broken.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(release_i && (credits_q == FULL)));
        end
    end

endmodule

// File: rtl/rpc_trx_scheduler.sv
// rpc_trx_scheduler
// Arbitrates pending AXI write and read transactions and hands one command at
// a time to the DRAM command FSM. Writes need B-FIFO space; reads need enough
// read-SRAM credits for all their beats. Grants alternate when both sides are
// eligible; a read starved by repeated write grants eventually holds writes off.
// Ports:
//   clk_i, rst_i                           clock, asynchronous active-high reset
//   wr_valid_i/addr/len, wr_ready_o        write request and one-cycle accept pulse
//   rd_valid_i/addr/len, rd_ready_o        read request and one-cycle accept pulse
//   b_space_i                              B-response FIFO can take one entry
//   r_pop_i                                one read word left the SRAM
//   cmd_valid_o/ready_i/is_write/addr/len  command toward the DRAM FSM
//   credits_o                              free read-SRAM words
//   busy_o                                 a command is being offered
//   stat_wr_o, stat_rd_o, stat_stall_o     grant/stall counters
// Build option: RPC_SCHED_STATS_EN enables the statistics counters; without it
// the stat ports read as zero and no counter registers exist.
module rpc_trx_scheduler
    import rpc_sched_pkg::*;
#(
    parameter int unsigned  BufferDepth  = 4,
    parameter int unsigned  DramLenWidth = LEN_WIDTH,
    parameter int unsigned  AddrWidth    = ADDR_WIDTH,
    parameter int unsigned  MaxStarve    = 4,
    localparam int unsigned RDepth       = $clog2(rbuf_depth(BufferDepth, DramLenWidth))
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_valid_i,
    input  logic [AddrWidth-1:0]    wr_addr_i,
    input  logic [DramLenWidth-1:0] wr_len_i,
    output logic                    wr_ready_o,
    input  logic                    rd_valid_i,
    input  logic [AddrWidth-1:0]    rd_addr_i,
    input  logic [DramLenWidth-1:0] rd_len_i,
    output logic                    rd_ready_o,
    input  logic                    b_space_i,
    input  logic                    r_pop_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic                    cmd_is_write_o,
    output logic [AddrWidth-1:0]    cmd_addr_o,
    output logic [DramLenWidth-1:0] cmd_len_o,
    output logic [RDepth:0]         credits_o,
    output logic                    busy_o,
    output logic [31:0]             stat_wr_o,
    output logic [31:0]             stat_rd_o,
    output logic [31:0]             stat_stall_o
);

    localparam int unsigned    SW       = $clog2(MaxStarve + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(MaxStarve);

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          last_wr_q, last_wr_d;
    logic [SW-1:0] starve_q, starve_d;

    logic rd_space;
    logic wr_hold;
    logic wr_elig;
    logic rd_elig;
    logic can_grant;
    logic wr_grant;
    logic rd_grant;

    rpc_read_credit_counter #(
        .BufferDepth  (BufferDepth),
        .DramLenWidth (DramLenWidth)
    ) u_credits (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_len_i     (rd_len_i),
        .space_ok_o    (rd_space),
        .reserve_i     (rd_grant),
        .reserve_len_i (rd_len_i),
        .release_i     (r_pop_i),
        .credits_o     (credits_o)
    );

    // Once a blocked read has been bypassed MaxStarve times, writes are
    // ineligible until that read finally wins a grant.
    assign wr_hold   = (starve_q == STARVE_MAX);
    assign wr_elig   = wr_valid_i && b_space_i && !wr_hold;
    assign rd_elig   = rd_valid_i && rd_space;
    assign can_grant = (state_q == IDLE) && !rst_i;

    // With both sides eligible the side that did not win last time goes.
    assign wr_grant = can_grant && wr_elig && (!rd_elig || !last_wr_q);
    assign rd_grant = can_grant && rd_elig && (!wr_elig || last_wr_q);

    // Next-state: latch the granted request and offer it until accepted.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        last_wr_d = last_wr_q;
        starve_d  = starve_q;
        case (state_q)
            IDLE: begin
                if (wr_grant) begin
                    cmd_d     = '{is_write: 1'b1, addr: wr_addr_i, len: wr_len_i};
                    last_wr_d = 1'b1;
                    state_d   = ISSUE;
                    if (rd_valid_i && !rd_elig && !wr_hold) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (rd_grant) begin
                    cmd_d     = '{is_write: 1'b0, addr: rd_addr_i, len: rd_len_i};
                    last_wr_d = 1'b0;
                    starve_d  = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset drops any command in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            last_wr_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            last_wr_q <= last_wr_d;
            starve_q  <= starve_d;
        end
    end

    assign wr_ready_o     = wr_grant;
    assign rd_ready_o     = rd_grant;
    assign cmd_valid_o    = (state_q == ISSUE);
    assign cmd_is_write_o = cmd_q.is_write;
    assign cmd_addr_o     = cmd_q.addr;
    assign cmd_len_o      = cmd_q.len;
    assign busy_o         = (state_q != IDLE);

`ifdef RPC_SCHED_STATS_EN
    logic [31:0] stat_wr_q;
    logic [31:0] stat_rd_q;
    logic [31:0] stat_stall_q;

    // Free-running wrapping counters of grants and of stalled request cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_wr_q    <= '0;
            stat_rd_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (wr_grant) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
            if (rd_grant) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if ((wr_valid_i || rd_valid_i) && !wr_elig && !rd_elig) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_wr_o    = stat_wr_q;
    assign stat_rd_o    = stat_rd_q;
    assign stat_stall_o = stat_stall_q;
`else
    assign stat_wr_o    = '0;
    assign stat_rd_o    = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_rpc_trx_scheduler.sv
// tb_rpc_trx_scheduler
// Self-checking bench for rpc_trx_scheduler: a table of per-cycle vectors,
// directed multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_rpc_trx_scheduler;

    localparam int FULL_CREDITS = 256;
    localparam int MAX_STARVE   = 4;

    typedef struct {
        logic        wr_valid;
        logic [26:0] wr_addr;
        logic [5:0]  wr_len;
        logic        rd_valid;
        logic [26:0] rd_addr;
        logic [5:0]  rd_len;
        logic        b_space;
        logic        cmd_ready;
        logic        r_pop;
    } stim_t;

    typedef struct {
        stim_t       stim;
        logic        wr_ready;
        logic        rd_ready;
        logic        cmd_valid;
        logic        is_write;
        logic [26:0] addr;
        logic [5:0]  len;
        int          credits;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_valid_i, rd_valid_i, b_space_i, r_pop_i, cmd_ready_i;
    logic [26:0] wr_addr_i, rd_addr_i;
    logic [5:0]  wr_len_i, rd_len_i;
    logic        wr_ready_o, rd_ready_o, cmd_valid_o, cmd_is_write_o, busy_o;
    logic [26:0] cmd_addr_o;
    logic [5:0]  cmd_len_o;
    logic [8:0]  credits_o;
    logic [31:0] stat_wr_o, stat_rd_o, stat_stall_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding command, free words, arbitration memory.
    bit          m_busy;
    bit          m_cmd_wr;
    logic [26:0] m_cmd_addr;
    logic [5:0]  m_cmd_len;
    int          m_credits;
    bit          m_last_wr;
    int          m_starve;

    rpc_trx_scheduler dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .wr_len_i       (wr_len_i),
        .wr_ready_o     (wr_ready_o),
        .rd_valid_i     (rd_valid_i),
        .rd_addr_i      (rd_addr_i),
        .rd_len_i       (rd_len_i),
        .rd_ready_o     (rd_ready_o),
        .b_space_i      (b_space_i),
        .r_pop_i        (r_pop_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_ready_i    (cmd_ready_i),
        .cmd_is_write_o (cmd_is_write_o),
        .cmd_addr_o     (cmd_addr_o),
        .cmd_len_o      (cmd_len_o),
        .credits_o      (credits_o),
        .busy_o         (busy_o),
        .stat_wr_o      (stat_wr_o),
        .stat_rd_o      (stat_rd_o),
        .stat_stall_o   (stat_stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Global time bound so a stuck run still ends with a report.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic stim_t zero_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic vec_t mk(input logic wv, input logic [26:0] wa, input logic [5:0] wl,
                                input logic rv, input logic [26:0] ra, input logic [5:0] rl,
                                input logic bs, input logic cr, input logic rp,
                                input logic e_wr, input logic e_rd, input logic e_cv,
                                input logic e_iw, input logic [26:0] e_addr,
                                input logic [5:0] e_len, input int e_cred);
        vec_t v;
        v.stim.wr_valid  = wv;
        v.stim.wr_addr   = wa;
        v.stim.wr_len    = wl;
        v.stim.rd_valid  = rv;
        v.stim.rd_addr   = ra;
        v.stim.rd_len    = rl;
        v.stim.b_space   = bs;
        v.stim.cmd_ready = cr;
        v.stim.r_pop     = rp;
        v.wr_ready  = e_wr;
        v.rd_ready  = e_rd;
        v.cmd_valid = e_cv;
        v.is_write  = e_iw;
        v.addr      = e_addr;
        v.len       = e_len;
        v.credits   = e_cred;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge and let outputs settle.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk_i);
        wr_valid_i  = s.wr_valid;
        wr_addr_i   = s.wr_addr;
        wr_len_i    = s.wr_len;
        rd_valid_i  = s.rd_valid;
        rd_addr_i   = s.rd_addr;
        rd_len_i    = s.rd_len;
        b_space_i   = s.b_space;
        cmd_ready_i = s.cmd_ready;
        r_pop_i     = s.r_pop;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        applyStimulus(zero_stim());
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Count read/write grants over n cycles of a fixed stimulus.
    task automatic run_count(input stim_t s, input int n, output int wr_cnt, output int rd_cnt);
        wr_cnt = 0;
        rd_cnt = 0;
        for (int c = 0; c < n; c++) begin
            applyStimulus(s);
            if (wr_ready_o) wr_cnt++;
            if (rd_ready_o) rd_cnt++;
        end
    endtask

    // Apply s until n reads are granted or the budget runs out.
    task automatic grant_reads(input stim_t s, input int n, input string name);
        int got;
        got = 0;
        for (int c = 0; c < 20 * n && got < n; c++) begin
            applyStimulus(s);
            if (rd_ready_o) got++;
        end
        checkOutput(name, 64'(got), 64'(n));
    endtask

    task automatic model_reset();
        m_busy     = 0;
        m_cmd_wr   = 0;
        m_cmd_addr = '0;
        m_cmd_len  = '0;
        m_credits  = FULL_CREDITS;
        m_last_wr  = 0;
        m_starve   = 0;
    endtask

    // One cycle of the reference model: predict, compare, then advance.
    task automatic model_cycle(input stim_t s, input int cyc);
        bit we, re, gw, gr;
        we = s.wr_valid && s.b_space && (m_starve != MAX_STARVE);
        re = s.rd_valid && (int'(s.rd_len) + 1 <= m_credits);
        gw = 0;
        gr = 0;
        if (!m_busy) begin
            if (we && re) begin
                gw = !m_last_wr;
                gr = m_last_wr;
            end else begin
                gw = we;
                gr = re;
            end
        end
        checkOutput($sformatf("rnd%0d_ready", cyc), 64'({wr_ready_o, rd_ready_o}), 64'({gw, gr}));
        checkOutput($sformatf("rnd%0d_cmd", cyc),
                    64'({cmd_valid_o, cmd_is_write_o, cmd_addr_o, cmd_len_o}),
                    64'({m_busy, m_cmd_wr, m_cmd_addr, m_cmd_len}));
        checkOutput($sformatf("rnd%0d_credits", cyc), 64'(credits_o), 64'(m_credits));
        if (gw) begin
            if (s.rd_valid && !re) m_starve++;
            m_busy = 1; m_cmd_wr = 1; m_cmd_addr = s.wr_addr; m_cmd_len = s.wr_len;
            m_last_wr = 1;
        end else if (gr) begin
            m_starve = 0;
            m_busy = 1; m_cmd_wr = 0; m_cmd_addr = s.rd_addr; m_cmd_len = s.rd_len;
            m_last_wr = 0;
            m_credits -= int'(s.rd_len) + 1;
        end else if (m_busy && s.cmd_ready) begin
            m_busy = 0;
        end
        if (s.r_pop) m_credits++;
    endtask

    initial begin
        vec_t  vecs[10];
        stim_t s;
        int    wr_cnt, rd_cnt;
        int    n_cmds;
        bit    exp_wr;

        vecs[0] = mk(1,'h100,3, 0,0,0,       1,0,0, 1,0, 0,0,'h000,0, 256);
        vecs[1] = mk(0,0,0,     0,0,0,       1,1,0, 0,0, 1,1,'h100,3, 256);
        vecs[2] = mk(1,'h200,1, 1,'h300,7,   1,0,0, 0,1, 0,1,'h100,3, 256);
        vecs[3] = mk(1,'h200,1, 1,'h300,7,   1,1,0, 0,0, 1,0,'h300,7, 248);
        vecs[4] = mk(1,'h200,1, 1,'h300,7,   1,0,0, 1,0, 0,0,'h300,7, 248);
        vecs[5] = mk(1,'h200,1, 1,'h300,7,   1,1,0, 0,0, 1,1,'h200,1, 248);
        vecs[6] = mk(1,'h200,1, 1,'h300,7,   1,0,0, 0,1, 0,1,'h200,1, 248);
        vecs[7] = mk(0,0,0,     0,0,0,       1,1,1, 0,0, 1,0,'h300,7, 240);
        vecs[8] = mk(0,0,0,     0,0,0,       1,0,0, 0,0, 0,0,'h300,7, 241);
        vecs[9] = mk(1,'h400,2, 0,0,0,       0,0,0, 0,0, 0,0,'h300,7, 241);

        // Reset state, sampled while reset is still held with a request pending.
        s = zero_stim();
        s.wr_valid = 1; s.b_space = 1; s.wr_addr = 27'h55;
        applyStimulus(s);
        rst_i = 1'b1;
        #2;
        checkOutput("reset_ready", 64'({wr_ready_o, rd_ready_o}), 64'(0));
        checkOutput("reset_cmd", 64'({cmd_valid_o, cmd_is_write_o, cmd_addr_o, cmd_len_o}), 64'(0));
        checkOutput("reset_credits", 64'(credits_o), 64'(FULL_CREDITS));
        checkOutput("reset_busy", 64'(busy_o), 64'(0));
        checkOutput("reset_stats", 64'({stat_wr_o, stat_rd_o, stat_stall_o}), 64'(0));
        do_reset();

        // Per-cycle vector table: first write, alternation, credits, B-space gating.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d_ready", i), 64'({wr_ready_o, rd_ready_o}),
                        64'({vecs[i].wr_ready, vecs[i].rd_ready}));
            checkOutput($sformatf("vec%0d_cmd", i),
                        64'({cmd_valid_o, cmd_is_write_o, cmd_addr_o, cmd_len_o}),
                        64'({vecs[i].cmd_valid, vecs[i].is_write, vecs[i].addr, vecs[i].len}));
            checkOutput($sformatf("vec%0d_credits", i), 64'(credits_o), 64'(vecs[i].credits));
        end

        // Both sides always eligible: commands alternate starting with a write.
        do_reset();
        s = zero_stim();
        s.wr_valid = 1; s.wr_addr = 27'h10; s.wr_len = 2; s.b_space = 1;
        s.rd_valid = 1; s.rd_addr = 27'h20; s.rd_len = 0; s.cmd_ready = 1;
        exp_wr = 1;
        n_cmds = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(s);
            if (cmd_valid_o) begin
                checkOutput($sformatf("alt_cmd%0d_is_write", n_cmds), 64'(cmd_is_write_o), 64'(exp_wr));
                exp_wr = !exp_wr;
                n_cmds++;
            end
        end
        checkOutput("alt_cmd_count", 64'(n_cmds), 64'(8));

        // Four full-length reads drain the SRAM; the fifth waits for 64 pops.
        do_reset();
        s = zero_stim();
        s.rd_valid = 1; s.rd_addr = 27'h40; s.rd_len = 63; s.cmd_ready = 1;
        grant_reads(s, 4, "drain_four_grants");
        applyStimulus(s);
        checkOutput("drain_credits_zero", 64'(credits_o), 64'(0));
        run_count(s, 10, wr_cnt, rd_cnt);
        checkOutput("drain_stall_no_grant", 64'(rd_cnt), 64'(0));
        s.r_pop = 1;
        run_count(s, 64, wr_cnt, rd_cnt);
        checkOutput("drain_pop_no_early_grant", 64'(rd_cnt), 64'(0));
        s.r_pop = 0;
        applyStimulus(s);
        checkOutput("drain_refill_credits", 64'(credits_o), 64'(64));
        checkOutput("drain_refill_grant", 64'(rd_ready_o), 64'(1));

        // Starved read: credits=10, writes continuous -> 4 writes then hold.
        do_reset();
        s = zero_stim();
        s.rd_valid = 1; s.rd_len = 63; s.cmd_ready = 1;
        grant_reads(s, 3, "starve_setup_three");
        s.rd_len = 53;
        grant_reads(s, 1, "starve_setup_fourth");
        s = zero_stim();
        s.rd_valid = 1; s.rd_addr = 27'h77; s.rd_len = 63;
        s.wr_valid = 1; s.wr_addr = 27'h88; s.wr_len = 5; s.b_space = 1; s.cmd_ready = 1;
        run_count(s, 30, wr_cnt, rd_cnt);
        checkOutput("starve_write_grants", 64'(wr_cnt), 64'(4));
        checkOutput("starve_no_read", 64'(rd_cnt), 64'(0));
        checkOutput("starve_credits", 64'(credits_o), 64'(10));
        s.r_pop = 1;
        run_count(s, 54, wr_cnt, rd_cnt);
        checkOutput("starve_hold_writes", 64'(wr_cnt), 64'(0));
        checkOutput("starve_hold_reads", 64'(rd_cnt), 64'(0));
        s.r_pop = 0;
        applyStimulus(s);
        checkOutput("starve_read_credits", 64'(credits_o), 64'(64));
        checkOutput("starve_read_grant", 64'({wr_ready_o, rd_ready_o}), 64'(1));

        // Pop during a read grant, then a command held for five cycles.
        do_reset();
        s = zero_stim();
        s.rd_valid = 1; s.rd_addr = 27'h55; s.rd_len = 15; s.cmd_ready = 1;
        grant_reads(s, 1, "hold_setup_grant");
        applyStimulus(s);
        s = zero_stim();
        s.rd_valid = 1; s.rd_addr = 27'h777; s.rd_len = 7; s.r_pop = 1;
        applyStimulus(s);
        checkOutput("hold_grant", 64'(rd_ready_o), 64'(1));
        checkOutput("hold_credits_before", 64'(credits_o), 64'(240));
        s = zero_stim();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(s);
            checkOutput($sformatf("hold_cyc%0d_cmd", c),
                        64'({cmd_valid_o, cmd_is_write_o, cmd_addr_o, cmd_len_o}),
                        64'({1'b1, 1'b0, 27'h777, 6'd7}));
        end
        checkOutput("hold_credits_net", 64'(credits_o), 64'(233));
        s.cmd_ready = 1;
        applyStimulus(s);
        checkOutput("hold_handshake_valid", 64'(cmd_valid_o), 64'(1));
        applyStimulus(s);
        checkOutput("hold_after_handshake", 64'(cmd_valid_o), 64'(0));

        // Reset arriving while a command is offered.
        do_reset();
        s = zero_stim();
        s.rd_valid = 1; s.rd_addr = 27'h99; s.rd_len = 31;
        grant_reads(s, 1, "midreset_grant");
        s = zero_stim();
        applyStimulus(s);
        checkOutput("midreset_issuing", 64'({cmd_valid_o, credits_o}), 64'({1'b1, 9'd224}));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midreset_valid", 64'({cmd_valid_o, busy_o}), 64'(0));
        checkOutput("midreset_credits", 64'(credits_o), 64'(FULL_CREDITS));
        checkOutput("midreset_stats", 64'({stat_wr_o, stat_rd_o, stat_stall_o}), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            s.wr_valid  = ($urandom_range(0, 9) < 7);
            s.wr_addr   = 27'($urandom);
            s.wr_len    = 6'($urandom);
            s.rd_valid  = ($urandom_range(0, 9) < 7);
            s.rd_addr   = 27'($urandom);
            s.rd_len    = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63))
                                                       : 6'($urandom_range(0, 7));
            s.b_space   = ($urandom_range(0, 9) < 8);
            s.cmd_ready = ($urandom_range(0, 9) < 6);
            s.r_pop     = ($urandom_range(0, 1) == 1) && (m_credits < FULL_CREDITS);
            applyStimulus(s);
            model_cycle(s, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
